// File: rtl/event_logger.sv
// event_logger: circular log of time-stamped events.
// Each event stores {code, hours, minutes, seconds}. When the log is full,
// a new event overwrites the oldest one and sets the sticky overflow flag.
// Pops return the oldest entry one cycle later on the rd_* outputs, which
// then hold their value until the next successful pop.
module event_logger #(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     ev_valid,
  input  logic [CODE_W-1:0]        ev_code,
  input  logic [5:0]               seconds,
  input  logic [5:0]               minutes,
  input  logic [4:0]               hours,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [CODE_W-1:0]        rd_code,
  output logic [5:0]               rd_seconds,
  output logic [5:0]               rd_minutes,
  output logic [4:0]               rd_hours,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = CODE_W + 17;

  localparam logic [PTR_W-1:0]   PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);
  localparam logic [ENTRY_W-1:0] ENTRY_ZERO = ENTRY_W'(0);

  // Storage is never reset; only pointers and count define what is valid.
  logic [ENTRY_W-1:0] mem_r [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               overflow_r;
  logic               rd_valid_r;
  logic [ENTRY_W-1:0] rd_entry_r;
  logic               empty_r;
  logic               full_r;

  logic               push_s;
  logic               pop_s;
  logic               is_full_s;
  logic [PTR_W-1:0]   wr_ptr_nxt_s;
  logic [PTR_W-1:0]   rd_ptr_nxt_s;
  logic [CNT_W-1:0]   count_nxt_s;
  logic               overflow_nxt_s;
  logic [ENTRY_W-1:0] entry_s;

  assign entry_s = {ev_code, hours, minutes, seconds};

  // Decide push/pop and compute next pointer, count and overflow state.
  always_comb begin
    push_s         = ev_valid;
    pop_s          = rd_req && (count_r != CNT_ZERO);
    is_full_s      = (count_r == CNT_FULL);
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    count_nxt_s    = count_r;
    overflow_nxt_s = overflow_r;
    case ({push_s, pop_s})
      2'b11: begin
        // Pop frees a slot first, so the push never overflows; count unchanged.
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end
      2'b01: begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        count_nxt_s  = count_r - CNT_ONE;
      end
      2'b10: begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        if (is_full_s) begin
          // Overwrite the oldest entry: the read side skips past it.
          rd_ptr_nxt_s   = rd_ptr_r + PTR_ONE;
          overflow_nxt_s = 1'b1;
        end else begin
          count_nxt_s = count_r + CNT_ONE;
        end
      end
      default: begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
    endcase
  end

  // Control registers and read-data outputs; reset beats clear beats traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_entry_r <= ENTRY_ZERO;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
    end else if (clear) begin
      // Flush the log but leave the last popped data on rd_*.
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
      rd_valid_r <= 1'b0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      overflow_r <= overflow_nxt_s;
      rd_valid_r <= pop_s;
      empty_r    <= (count_nxt_s == CNT_ZERO);
      full_r     <= (count_nxt_s == CNT_FULL);
      if (pop_s) begin
        rd_entry_r <= mem_r[rd_ptr_r];
      end
    end
  end

  // Entry storage write; a full pop+push reuses the slot being read this cycle.
  always_ff @(posedge clk) begin
    if (!reset && !clear && push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  assign rd_valid   = rd_valid_r;
  assign rd_code    = rd_entry_r[ENTRY_W-1 -: CODE_W];
  assign rd_hours   = rd_entry_r[16:12];
  assign rd_minutes = rd_entry_r[11:6];
  assign rd_seconds = rd_entry_r[5:0];
  assign count      = count_r;
  assign empty      = empty_r;
  assign full       = full_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_event_logger.sv
// Testbench for event_logger: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue model.
module tb_event_logger;

  localparam int DEPTH  = 8;
  localparam int CODE_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clear = 1'b0;
  logic              ev_valid = 1'b0;
  logic [CODE_W-1:0] ev_code = '0;
  logic [5:0]        seconds = '0;
  logic [5:0]        minutes = '0;
  logic [4:0]        hours = '0;
  logic              rd_req = 1'b0;
  logic              rd_valid;
  logic [CODE_W-1:0] rd_code;
  logic [5:0]        rd_seconds;
  logic [5:0]        rd_minutes;
  logic [4:0]        rd_hours;
  logic [3:0]        count;
  logic              empty;
  logic              full;
  logic              overflow;

  event_logger #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .ev_valid(ev_valid),
    .ev_code(ev_code), .seconds(seconds), .minutes(minutes), .hours(hours),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_code(rd_code),
    .rd_seconds(rd_seconds), .rd_minutes(rd_minutes), .rd_hours(rd_hours),
    .count(count), .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: a queue of {code, hours, minutes, seconds} records.
  logic [CODE_W+16:0] mq[$];
  bit                 m_ovf;
  bit                 m_rv;
  logic [CODE_W+16:0] m_rd;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit do_pop;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = '0;
    end else if (clear) begin
      mq.delete();
      m_ovf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      do_pop = rd_req && (mq.size() > 0);
      m_rv = do_pop;
      if (do_pop) m_rd = mq.pop_front();
      if (ev_valid) begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          m_ovf = 1'b1;
        end
        mq.push_back({ev_code, hours, minutes, seconds});
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",    count,      mq.size());
      chk("empty",    empty,      mq.size() == 0);
      chk("full",     full,       mq.size() == DEPTH);
      chk("overflow", overflow,   m_ovf);
      chk("rd_valid", rd_valid,   m_rv);
      chk("rd_code",  rd_code,    m_rd[CODE_W+16 -: CODE_W]);
      chk("rd_hours", rd_hours,   m_rd[16:12]);
      chk("rd_min",   rd_minutes, m_rd[11:6]);
      chk("rd_sec",   rd_seconds, m_rd[5:0]);
    end
  end

  task automatic step(input logic r, input logic c, input logic e,
                      input logic [CODE_W-1:0] cd, input logic [4:0] h,
                      input logic [5:0] mi, input logic [5:0] s, input logic rq);
    reset = r; clear = c; ev_valid = e; ev_code = cd;
    hours = h; minutes = mi; seconds = s; rd_req = rq;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic push(input int code);
    step(1'b0, 1'b0, 1'b1, CODE_W'(code), 5'($urandom_range(0, 31)),
         6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
  endtask

  task automatic push_pop(input int code);
    step(1'b0, 1'b0, 1'b1, CODE_W'(code), 5'd3, 6'd4, 6'd5, 1'b1);
  endtask

  task automatic flush();
    step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    chk_en = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rd_code", rd_code, 0);

    // Scenario 1: single event at 12:34:56 then pop.
    step(1'b0, 1'b0, 1'b1, 3'd2, 5'd12, 6'd34, 6'd56, 1'b0);
    chk("s1_count", count, 1);
    pop();
    chk("s1_rd_valid", rd_valid, 1);
    chk("s1_code", rd_code, 2);
    chk("s1_hours", rd_hours, 12);
    chk("s1_minutes", rd_minutes, 34);
    chk("s1_seconds", rd_seconds, 56);
    chk("s1_empty", empty, 1);
    idle();
    chk("s1_pulse", rd_valid, 0);

    // Scenario 2: fill exactly, drain in order with back-to-back pops.
    for (int i = 0; i < 8; i++) push(i);
    chk("s2_full", full, 1);
    chk("s2_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      pop();
      chk("s2_rv", rd_valid, 1);
      chk("s2_code", rd_code, i);
    end
    chk("s2_empty", empty, 1);

    // Scenario 3: one event past full overwrites the oldest.
    for (int i = 0; i < 8; i++) push(i);
    push(1);
    chk("s3_ovf", overflow, 1);
    chk("s3_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      pop();
      chk("s3_code", rd_code, (i < 7) ? i + 1 : 1);
    end

    // Scenario 4: simultaneous push and pop when empty, count=3, full.
    flush();
    push_pop(5);
    chk("s4a_count", count, 1);
    chk("s4a_rv", rd_valid, 0);
    chk("s4a_ovf", overflow, 0);
    flush();
    for (int i = 0; i < 3; i++) push(i);
    push_pop(6);
    chk("s4b_count", count, 3);
    chk("s4b_rv", rd_valid, 1);
    chk("s4b_ovf", overflow, 0);
    flush();
    for (int i = 0; i < 8; i++) push(7 - i);
    push_pop(4);
    chk("s4c_count", count, 8);
    chk("s4c_rv", rd_valid, 1);
    chk("s4c_code", rd_code, 7);
    chk("s4c_ovf", overflow, 0);

    // Scenario 5: pop on empty is ignored and rd_* hold.
    flush();
    pop();
    chk("s5_rv", rd_valid, 0);
    chk("s5_code", rd_code, 7);

    // Scenario 6: clear beats a same-cycle event; reset mid-stream.
    for (int i = 0; i < 9; i++) push(i);
    for (int i = 0; i < 3; i++) pop();
    chk("s6_count5", count, 5);
    chk("s6_ovf1", overflow, 1);
    step(1'b0, 1'b1, 1'b1, 3'd3, 5'd1, 6'd2, 6'd3, 1'b0);
    chk("s6_clr_count", count, 0);
    chk("s6_clr_ovf", overflow, 0);
    idle();
    chk("s6_nothing_stored", empty, 1);
    push(2); push(3); pop();
    step(1'b1, 1'b1, 1'b1, 3'd5, 5'd9, 6'd9, 6'd9, 1'b1);
    chk("s6_rst_count", count, 0);
    chk("s6_rst_rv", rd_valid, 0);
    chk("s6_rst_code", rd_code, 0);
    chk("s6_rst_hours", rd_hours, 0);
    chk("s6_rst_empty", empty, 1);

    // Randomized traffic checked by the per-cycle model comparison.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 1)), CODE_W'($urandom),
           5'($urandom), 6'($urandom), 6'($urandom),
           1'($urandom_range(0, 9) < 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
